// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port req/ack arbiter driving an 8-bit async SRAM.
// Optional round-robin tie-break: define SRAM_ARB_RR_EN.
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [7:0]        a_data_i,
    output logic              a_ack_o,
    output logic [7:0]        a_data_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [7:0]        b_data_i,
    output logic              b_ack_o,
    output logic [7:0]        b_data_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [7:0]        sram_data_o,
    input  logic [7:0]        sram_data_i,
    output logic              sram_data_oe_o,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o,
    output logic              busy_o,
    output logic              grant_b_o
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              doe_q, doe_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              grant_b_q, grant_b_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [7:0]        a_rdata_q, a_rdata_d;
    logic [7:0]        b_rdata_q, b_rdata_d;
    logic              pick_b;
    logic              new_we;

`ifdef SRAM_ARB_RR_EN
    logic last_b_q, last_b_d;

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) last_b_q <= 1'b1;
        else            last_b_q <= last_b_d;
    end

    always_comb begin
        last_b_d = last_b_q;
        if (state_q == IDLE && (a_req_i || b_req_i)) last_b_d = pick_b;
    end

    assign pick_b = b_req_i && (!a_req_i || !last_b_q);
`else
    assign pick_b = !a_req_i;
`endif

    assign new_we = pick_b ? b_we_i : a_we_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        doe_d     = doe_q;
        we_n_d    = we_n_q;
        oe_n_d    = oe_n_q;
        grant_b_d = grant_b_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (a_req_i || b_req_i) begin
                    state_d   = SETUP;
                    grant_b_d = pick_b;
                    we_d      = new_we;
                    addr_d    = pick_b ? b_addr_i : a_addr_i;
                    if (new_we) wdata_d = pick_b ? b_data_i : a_data_i;
                    oe_n_d    = new_we;
                    doe_d     = new_we;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_LOAD;
                if (we_q) we_n_d = 1'b0;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    we_n_d  = 1'b1;
                    if (!we_q) begin
                        if (grant_b_q) b_rdata_d = sram_data_i;
                        else           a_rdata_d = sram_data_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                oe_n_d  = 1'b1;
                doe_d   = 1'b0;
                a_ack_d = !grant_b_q;
                b_ack_d = grant_b_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            doe_q     <= 1'b0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            grant_b_q <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            doe_q     <= doe_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            grant_b_q <= grant_b_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_ack_o        = a_ack_q;
    assign b_ack_o        = b_ack_q;
    assign a_data_o       = a_rdata_q;
    assign b_data_o       = b_rdata_q;
    assign sram_addr_o    = addr_q;
    assign sram_data_o    = wdata_q;
    assign sram_data_oe_o = doe_q;
    assign sram_we_n_o    = we_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign busy_o         = (state_q != IDLE);
    assign grant_b_o      = grant_b_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: transaction-level model plus directed and random traffic.
// Extra instances with WAIT_CYCLES 1 and 15 check access latency.
module tb_sram_arbiter;
    localparam int W = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [19:0] a_addr = 0, b_addr = 0;
    logic [7:0]  a_data = 0, b_data = 0;
    logic        a_ack, b_ack, sram_doe, sram_we_n, sram_oe_n, busy, grant_b;
    logic [7:0]  a_rd, b_rd, sram_dout, sram_din;
    logic [19:0] sram_addr;

    logic [7:0] mem [0:1048575];

    assign sram_din = sram_oe_n ? 8'hEE : mem[sram_addr];

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(W)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_data),
        .a_ack_o(a_ack), .a_data_o(a_rd),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_data),
        .b_ack_o(b_ack), .b_data_o(b_rd),
        .sram_addr_o(sram_addr), .sram_data_o(sram_dout), .sram_data_i(sram_din),
        .sram_data_oe_o(sram_doe), .sram_we_n_o(sram_we_n), .sram_oe_n_o(sram_oe_n),
        .busy_o(busy), .grant_b_o(grant_b)
    );

    // Latency sweep instances: port A read only.
    logic        s1_req = 0, s15_req = 0, s_zero = 0;
    logic [19:0] s_addr = 0, s_zaddr = 0;
    logic [7:0]  s_zdata = 0;
    logic        s1_ack, s15_ack, s1_back, s15_back;
    logic [7:0]  s1_rd, s15_rd, s1_brd, s15_brd, s1_dout, s15_dout, s1_din, s15_din;
    logic [19:0] s1_addr, s15_addr;
    logic        s1_doe, s1_wen, s1_oen, s1_busy, s1_gb;
    logic        s15_doe, s15_wen, s15_oen, s15_busy, s15_gb;

    assign s1_din  = s1_oen  ? 8'hEE : mem[s1_addr];
    assign s15_din = s15_oen ? 8'hEE : mem[s15_addr];

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) u_w1 (
        .clk_i(clk), .reset_n_i(reset_n),
        .a_req_i(s1_req), .a_we_i(s_zero), .a_addr_i(s_addr), .a_data_i(s_zdata),
        .a_ack_o(s1_ack), .a_data_o(s1_rd),
        .b_req_i(s_zero), .b_we_i(s_zero), .b_addr_i(s_zaddr), .b_data_i(s_zdata),
        .b_ack_o(s1_back), .b_data_o(s1_brd),
        .sram_addr_o(s1_addr), .sram_data_o(s1_dout), .sram_data_i(s1_din),
        .sram_data_oe_o(s1_doe), .sram_we_n_o(s1_wen), .sram_oe_n_o(s1_oen),
        .busy_o(s1_busy), .grant_b_o(s1_gb)
    );

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(15)) u_w15 (
        .clk_i(clk), .reset_n_i(reset_n),
        .a_req_i(s15_req), .a_we_i(s_zero), .a_addr_i(s_addr), .a_data_i(s_zdata),
        .a_ack_o(s15_ack), .a_data_o(s15_rd),
        .b_req_i(s_zero), .b_we_i(s_zero), .b_addr_i(s_zaddr), .b_data_i(s_zdata),
        .b_ack_o(s15_back), .b_data_o(s15_brd),
        .sram_addr_o(s15_addr), .sram_data_o(s15_dout), .sram_data_i(s15_din),
        .sram_data_oe_o(s15_doe), .sram_we_n_o(s15_wen), .sram_oe_n_o(s15_oen),
        .busy_o(s15_busy), .grant_b_o(s15_gb)
    );

    // Transaction model: t0 is the edge that sampled the winning request.
    int          m_ecnt, m_t0;
    logic        m_act, m_we, m_b, m_grant, m_last_b;
    logic [19:0] m_addr;
    logic [7:0]  m_wdata, m_ard, m_brd, m_exp;
    logic        m_idle, m_pick_b, m_nwe;
    logic [19:0] m_naddr;

    assign m_idle  = !m_act || (m_ecnt - m_t0 >= W + 2);
`ifdef SRAM_ARB_RR_EN
    assign m_pick_b = b_req && (!a_req || !m_last_b);
`else
    assign m_pick_b = !a_req;
`endif
    assign m_nwe   = m_pick_b ? b_we : a_we;
    assign m_naddr = m_pick_b ? b_addr : a_addr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act <= 0; m_we <= 0; m_b <= 0; m_grant <= 0; m_last_b <= 1;
            m_addr <= 0; m_wdata <= 0; m_ard <= 0; m_brd <= 0; m_exp <= 0;
            m_ecnt <= 0; m_t0 <= 0;
        end else begin
            m_ecnt <= m_ecnt + 1;
            if (m_act && !m_we && (m_ecnt + 1 - m_t0 == W + 1)) begin
                if (m_b) m_brd <= m_exp;
                else     m_ard <= m_exp;
            end
            if (m_idle && (a_req || b_req)) begin
                m_act    <= 1;
                m_t0     <= m_ecnt + 1;
                m_b      <= m_pick_b;
                m_grant  <= m_pick_b;
                m_last_b <= m_pick_b;
                m_we     <= m_nwe;
                m_addr   <= m_naddr;
                m_exp    <= mem[m_naddr];
                if (m_nwe) m_wdata <= m_pick_b ? b_data : a_data;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        int k;
        k = m_ecnt - m_t0;
        chk("busy", busy, m_act && k <= W + 1);
        chk("oe_n", sram_oe_n, !(m_act && !m_we && k <= W + 1));
        chk("data_oe", sram_doe, m_act && m_we && k <= W + 1);
        chk("we_n", sram_we_n, !(m_act && m_we && k >= 1 && k <= W));
        chk("a_ack", a_ack, m_act && !m_b && k == W + 2);
        chk("b_ack", b_ack, m_act && m_b && k == W + 2);
        chk("addr", sram_addr, m_addr);
        chk("wdata", sram_dout, m_wdata);
        chk("grant_b", grant_b, m_grant);
        chk("a_data", a_rd, m_ard);
        chk("b_data", b_rd, m_brd);
    endtask

    task automatic tick();
        @(negedge clk);
        if (!sram_we_n && sram_doe) mem[sram_addr] = sram_dout;
        compare();
    endtask

    task automatic access(input bit pb, input logic we, input logic [19:0] ad,
                          input logic [7:0] d, output int lat, output int oe_lo,
                          output int we_lo);
        int e0;
        e0 = m_ecnt;
        lat = -1; oe_lo = 0; we_lo = 0;
        if (pb) begin b_req = 1; b_we = we; b_addr = ad; b_data = d; end
        else    begin a_req = 1; a_we = we; a_addr = ad; a_data = d; end
        for (int i = 0; i < 40 && lat < 0; i++) begin
            tick();
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) we_lo++;
            if (pb ? b_ack : a_ack) lat = m_ecnt - (e0 + 1);
        end
        a_req = 0; b_req = 0;
        chk("ack_seen", lat >= 0, 1);
    endtask

    int lat, oe_lo, we_lo, n, na, nb, l1, l15;
    bit ord [0:3];
    logic gb [0:3];

    initial begin
        for (int i = 0; i < 1048576; i++) mem[i] = 8'h00;
        repeat (3) tick();
        reset_n = 1;
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_a_data", a_rd, 0);
        chk("reset_we_n", sram_we_n, 1);

        mem[20'h12345] = 8'hA5;
        access(0, 0, 20'h12345, 8'h00, lat, oe_lo, we_lo);
        chk("a_read_latency", lat, 4);
        chk("a_read_oe_cycles", oe_lo, 4);
        chk("a_read_data", a_rd, 8'hA5);

        access(1, 1, 20'h00200, 8'h3C, lat, oe_lo, we_lo);
        chk("b_write_we_cycles", we_lo, 2);
        chk("b_write_oe_cycles", oe_lo, 0);
        tick();
        chk("b_write_single_ack", b_ack, 0);
        chk("b_write_mem", mem[20'h00200], 8'h3C);

        // Simultaneous requests: A first, then B.
        a_req = 1; a_we = 0; a_addr = 20'h00010;
        b_req = 1; b_we = 1; b_addr = 20'h00020; b_data = 8'h5A;
        n = 0;
        for (int i = 0; i < 60 && n < 2; i++) begin
            tick();
            if (a_ack) begin ord[n] = 0; gb[n] = grant_b; n++; a_req = 0; end
            if (b_ack) begin ord[n] = 1; gb[n] = grant_b; n++; b_req = 0; end
        end
        a_req = 0; b_req = 0;
        chk("tie_count", n, 2);
        chk("tie_first_port", ord[0], 0);
        chk("tie_first_grant", gb[0], 0);
        chk("tie_second_port", ord[1], 1);
        chk("tie_second_grant", gb[1], 1);
        chk("tie_mem", mem[20'h00020], 8'h5A);

        // Continuous A traffic with B pending.
        a_req = 1; a_we = 0; a_addr = 20'h12345;
        b_req = 1; b_we = 0; b_addr = 20'h00200;
        na = 0; nb = 0; n = 0;
`ifdef SRAM_ARB_RR_EN
        for (int i = 0; i < 200 && n < 4; i++) begin
            tick();
            if (a_ack) begin ord[n] = 0; n++; na++; end
            if (b_ack) begin ord[n] = 1; n++; nb++; end
        end
        a_req = 0; b_req = 0;
        chk("rr_count", n, 4);
        chk("rr_0", ord[0], 0);
        chk("rr_1", ord[1], 1);
        chk("rr_2", ord[2], 0);
        chk("rr_3", ord[3], 1);
`else
        for (int i = 0; i < 400 && na < 20; i++) begin
            tick();
            if (a_ack) na++;
            if (b_ack) nb++;
        end
        a_req = 0;
        chk("starve_a_acks", na, 20);
        chk("starve_b_acks", nb, 0);
        for (int i = 0; i < 40 && nb == 0; i++) begin
            tick();
            if (b_ack) nb++;
        end
        b_req = 0;
        chk("starve_b_served", nb, 1);
        chk("starve_b_data", b_rd, 8'h3C);
`endif
        repeat (2) tick();

        // Reset in the middle of a write strobe.
        a_req = 1; a_we = 1; a_addr = 20'h00300; a_data = 8'h77;
        n = 0;
        for (int i = 0; i < 10 && sram_we_n; i++) tick();
        chk("midwrite_we_low", sram_we_n, 0);
        #2 reset_n = 0;
        #1;
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_data_oe", sram_doe, 0);
        chk("rst_busy", busy, 0);
        a_req = 0;
        repeat (3) begin tick(); if (a_ack) n++; end
        reset_n = 1;
        repeat (6) begin tick(); if (a_ack) n++; end
        chk("rst_no_ack", n, 0);
        chk("rst_busy_after", busy, 0);
        chk("rst_a_data", a_rd, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (a_req && a_ack) begin
                if ($urandom_range(0, 1) == 0) a_req = 0;
                else begin
                    a_we = $urandom_range(0, 1) == 1;
                    a_addr = 20'($urandom_range(0, 15)); a_data = 8'($urandom);
                end
            end else if (!a_req && $urandom_range(0, 9) < 3) begin
                a_req = 1; a_we = $urandom_range(0, 1) == 1;
                a_addr = 20'($urandom_range(0, 15)); a_data = 8'($urandom);
            end
            if (b_req && b_ack) begin
                if ($urandom_range(0, 1) == 0) b_req = 0;
                else begin
                    b_we = $urandom_range(0, 1) == 1;
                    b_addr = 20'($urandom_range(0, 15)); b_data = 8'($urandom);
                end
            end else if (!b_req && $urandom_range(0, 9) < 3) begin
                b_req = 1; b_we = $urandom_range(0, 1) == 1;
                b_addr = 20'($urandom_range(0, 15)); b_data = 8'($urandom);
            end
        end
        a_req = 0; b_req = 0;
        repeat (30) tick();

        // WAIT_CYCLES sweep.
        s_addr = 20'h12345; s1_req = 1; s15_req = 1;
        n = m_ecnt; l1 = -1; l15 = -1;
        for (int i = 0; i < 40 && (l1 < 0 || l15 < 0); i++) begin
            tick();
            if (s1_ack && l1 < 0)   begin l1 = m_ecnt - (n + 1); s1_req = 0; end
            if (s15_ack && l15 < 0) begin l15 = m_ecnt - (n + 1); s15_req = 0; end
        end
        s1_req = 0; s15_req = 0;
        chk("w1_latency", l1, 3);
        chk("w15_latency", l15, 17);
        chk("w1_data", s1_rd, 8'hA5);
        chk("w15_data", s15_rd, 8'hA5);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 8-bit asynchronous SRAM (20-bit address) between two requesters.
  - Port A: CPU/video side, latency-sensitive.
  - Port B: disk-image side, i.e. the SD sector buffer reader/writer.
- Serialises accesses with a req/ack handshake and generates SRAM strobes with programmable access width.
- Sits between the requesters and the top-level SRAM pins.

Parameters:
- ADDR_W, 20, SRAM address width.
- WAIT_CYCLES, 2, number of cycles the ACCESS state holds the strobe. Legal range 1..15; a 4-bit counter is used.

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- a_req_i  in  1  port A request level; held with addr/we/data until ack
- a_we_i  in  1  port A: 1 = write, 0 = read
- a_addr_i  in  ADDR_W  port A address
- a_data_i  in  8  port A write data
- a_ack_o  out  1  port A one-cycle completion pulse
- a_data_o  out  8  port A read data; valid from the ack cycle, held until the next port A read completes
- b_req_i, b_we_i, b_addr_i, b_data_i, b_ack_o, b_data_o: same as port A, for port B
- sram_addr_o  out  ADDR_W  SRAM address
- sram_data_o  out  8  SRAM write data
- sram_data_i  in  8  SRAM read data
- sram_data_oe_o  out  1  top-level tristate enable for sram_data_o
- sram_we_n_o  out  1  SRAM write strobe, active low
- sram_oe_n_o  out  1  SRAM output enable, active low
- busy_o  out  1  high in every state except IDLE
- grant_b_o  out  1  0 = port A owns the current or last access, 1 = port B

Behaviour:
- Reset (asynchronous, any state, including mid-access):
  - state = IDLE; counter = 0.
  - Outputs: sram_we_n_o = 1, sram_oe_n_o = 1, sram_data_oe_o = 0, sram_addr_o = 0, sram_data_o = 0.
  - a_ack_o = b_ack_o = 0; a_data_o = b_data_o = 0; busy_o = 0; grant_b_o = 0.
  - An interrupted access is dropped; no ack is issued for it.
- All outputs are registered.
- States: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Samples the req lines each edge.
  - If either is high, select the winner, latch its addr/we/data, set grant_b_o, go to SETUP.
  - If neither is high, stay in IDLE.
- Arbitration: fixed priority, A over B, when both req lines are high on the same edge.
- SETUP (1 cycle):
  - sram_addr_o is driven.
  - Read: sram_oe_n_o = 0.
  - Write: sram_data_oe_o = 1, sram_data_o = latched data; sram_we_n_o stays 1 (address setup).
  - Load counter = WAIT_CYCLES - 1.
- ACCESS (WAIT_CYCLES cycles):
  - Write: sram_we_n_o = 0.
  - Read: sram_oe_n_o stays 0.
  - Decrement the counter; leave when it reaches 0.
  - On the leaving edge of a read, capture sram_data_i into the winner's data_o.
- DONE (1 cycle):
  - sram_we_n_o = 1 (write hold: address and data are still driven).
  - Pulse the winner's ack_o = 1; go to IDLE.
  - On the exit edge: sram_oe_n_o = 1, sram_data_oe_o = 0.
- Latency:
  - A request sampled at edge N gives ack high in the cycle starting at edge N + WAIT_CYCLES + 2.
  - Minimum request-to-request spacing is WAIT_CYCLES + 3 cycles.
- Requester rule:
  - Drop req on the edge where ack is seen, unless issuing a new access.
  - A req still high in the following IDLE cycle is a new request.
- The losing requester keeps req high and is served in a later IDLE cycle.
- The non-winning port's ack_o and data_o are untouched.
- Changes on req, addr or data after grant have no effect on the access in flight.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- When defined: when both req lines are high in IDLE, the port not granted last wins (round-robin). Uses a last-grant bit, reset to B, so A wins the first tie after reset.
- When undefined: fixed A-over-B priority; port B can be starved by continuous port A traffic.

Test Plan:
- Reset then idle: reset_n_i = 0 mid-write (we_n low) -> all strobes immediately inactive, no ack; after release, busy_o = 0 and a_data_o = 0.
- Port A read: pre-load SRAM model 0x12345 = 0xA5; a_req_i, a_we_i = 0, WAIT_CYCLES = 2 -> oe_n low for 4 cycles, a_ack_o pulse 4 cycles after sampling, a_data_o = 0xA5.
- Port B write: 0x00200 = 0x3C -> we_n low exactly 2 cycles, with address and data stable one cycle before and after; SRAM model holds 0x3C; b_ack_o pulses once.
- Simultaneous requests, macro undefined: A read 0x00010 and B write 0x00020 raised on the same edge -> A served first, then B; grant_b_o sequence 0 then 1.
- Continuous A requests plus pending B:
  - Macro undefined: B never acked in 20 A accesses.
  - SRAM_ARB_RR_EN defined: grants alternate A, B, A, B.
- Sweep WAIT_CYCLES = 1 and 15: ack spacing is 3 and 17 cycles respectively from the sampling edge; read data is correct.
